// File: rtl/poly_feeder_pkg.sv
// Shared types and constants for the quadratic-evaluator feeder.
package poly_feeder_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_PULSE,
        ST_WAIT_RES
    } state_e;

    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;
    localparam logic [1:0] IDX_X = 2'd3;

endpackage

// File: rtl/poly_feeder_out_reg.sv
// One-entry result holding register; a capture wins over a same-cycle drain.
module poly_feeder_out_reg
    import poly_feeder_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              capture_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (capture_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/poly_feeder.sv
// Replays an {a,b,c,x} tuple onto the evaluator Go/DataIn pins and captures the result.
// Optional result-wait timeout: define POLY_FEEDER_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | ready for a new tuple, Go low
// ST_PRESENT  | operand idx on DataIn, Go low for one cycle
// ST_PULSE    | Go high for GO_CYCLES cycles with operand idx held
// ST_WAIT_RES | all operands sent, waiting for ResultValid and a free output slot
module poly_feeder
    import poly_feeder_pkg::*;
#(
    parameter int GO_CYCLES = 2
`ifdef POLY_FEEDER_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 31
`endif
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic [DATA_W-1:0] in_x,
    output logic              Go,
    output logic [DATA_W-1:0] DataIn,
    input  logic              ResultValid,
    input  logic [DATA_W-1:0] DataResult,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
`ifdef POLY_FEEDER_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam int PW = (GO_CYCLES > 1) ? $clog2(GO_CYCLES) : 1;

    state_e                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic [3:0][DATA_W-1:0] ops_q;
    logic                   go_q, go_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   accept, capture, slot_free;

`ifdef POLY_FEEDER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          terr_q, terr_d;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pcnt_d  = pcnt_q;
        capture = 1'b0;
`ifdef POLY_FEEDER_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        terr_d  = terr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PRESENT;
                    idx_d   = IDX_A;
                end
            end
            ST_PRESENT: begin
                state_d = ST_PULSE;
                pcnt_d  = PW'(GO_CYCLES - 1);
            end
            ST_PULSE: begin
                if (pcnt_q != '0) begin
                    pcnt_d = pcnt_q - PW'(1);
                end else if (idx_q == IDX_X) begin
                    state_d = ST_WAIT_RES;
`ifdef POLY_FEEDER_TIMEOUT_EN
                    tcnt_d  = TW'(TIMEOUT - 1);
`endif
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_PRESENT;
                end
            end
            ST_WAIT_RES: begin
                // With the slot full the evaluator keeps its result while Go stays low.
                if (ResultValid && slot_free) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef POLY_FEEDER_TIMEOUT_EN
                else if (!ResultValid) begin
                    if (tcnt_q == '0) begin
                        terr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q - TW'(1);
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin values are computed from the next state so Go/DataIn stay registered.
    always_comb begin
        go_d   = (state_d == ST_PULSE);
        data_d = data_q;
        if (accept) begin
            data_d = in_a;
        end else if (state_d != ST_IDLE) begin
            data_d = ops_q[idx_d];
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_A;
            pcnt_q  <= '0;
            ops_q   <= '0;
            go_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pcnt_q  <= pcnt_d;
            go_q    <= go_d;
            data_q  <= data_d;
            if (accept) begin
                ops_q[IDX_A] <= in_a;
                ops_q[IDX_B] <= in_b;
                ops_q[IDX_C] <= in_c;
                ops_q[IDX_X] <= in_x;
            end
        end
    end

`ifdef POLY_FEEDER_TIMEOUT_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tcnt_q <= '0;
            terr_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`endif

    assign Go     = go_q;
    assign DataIn = data_q;

    poly_feeder_out_reg u_out_reg (
        .clk_i     (Clock),
        .rst_n_i   (Resetn),
        .capture_i (capture),
        .data_i    (DataResult),
        .ready_i   (out_ready),
        .valid_o   (out_valid),
        .data_o    (out_data)
    );

endmodule

// File: tb/tb_poly_feeder.sv
// Directed bench for poly_feeder with a behavioural Go-pulse evaluator attached.
module tb_poly_feeder;

    logic       Clock;
    logic       Resetn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b, in_c, in_x;
    logic       Go;
    logic [7:0] DataIn;
    logic       ResultValid;
    logic [7:0] DataResult;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
`ifdef POLY_FEEDER_TIMEOUT_EN
    logic       timeout_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Evaluator model: captures DataIn on each Go rise (A,B,C,X), result 6 cycles after WAIT_RES entry.
    logic       ev_prev, ev_have_x, ev_rv, rv_kill;
    logic [1:0] ev_k;
    logic [2:0] ev_cnt;
    logic [7:0] ev_op [4];
    logic [7:0] ev_res;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ev_prev   <= 1'b0;
            ev_have_x <= 1'b0;
            ev_rv     <= 1'b0;
            ev_k      <= 2'd0;
            ev_cnt    <= 3'd0;
            ev_res    <= 8'd0;
        end else begin
            ev_prev <= Go;
            if (Go && !ev_prev) begin
                ev_op[ev_k] <= DataIn;
                if (ev_k == 2'd0) ev_rv <= 1'b0;
                if (ev_k == 2'd3) ev_have_x <= 1'b1;
                ev_k <= ev_k + 2'd1;
            end
            if (!Go && ev_prev && ev_have_x) begin
                ev_have_x <= 1'b0;
                ev_cnt    <= 3'd5;
            end
            if (ev_cnt != 3'd0) begin
                ev_cnt <= ev_cnt - 3'd1;
                if (ev_cnt == 3'd1) begin
                    ev_rv  <= 1'b1;
                    ev_res <= 8'(ev_op[0] * ev_op[3] * ev_op[3] + ev_op[1] * ev_op[3] + ev_op[2]);
                end
            end
        end
    end

    assign ResultValid = ev_rv && !rv_kill;
    assign DataResult  = ev_res;

    poly_feeder #(
        .GO_CYCLES (2)
`ifdef POLY_FEEDER_TIMEOUT_EN
        ,
        .TIMEOUT   (31)
`endif
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_c        (in_c),
        .in_x        (in_x),
        .Go          (Go),
        .DataIn      (DataIn),
        .ResultValid (ResultValid),
        .DataResult  (DataResult),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy)
`ifdef POLY_FEEDER_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] x);
        in_valid = 1'b1;
        in_a = a; in_b = b; in_c = c; in_x = x;
        @(posedge Clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Accept a tuple, check the Go/DataIn sequence, then the latency and the result.
    task automatic run_tuple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] x, input logic [7:0] exp_res);
        logic [11:0] pat;
        int          lat;
        pat = '0;
        accept(a, b, c, x);
        check("in_ready_low_after_accept", in_ready, 0);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            pat = {pat[10:0], Go};
            if (i == 1)  check("datain_a", DataIn, a);
            if (i == 4)  check("datain_b", DataIn, b);
            if (i == 10) check("datain_x", DataIn, x);
        end
        check("go_pattern", pat, 12'b011_011_011_011);
        lat = 11;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("latency_edges", lat, 19);
        check("out_data", out_data, exp_res);
    endtask

    initial begin
        Resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rv_kill = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_x = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_go", Go, 0);
        check("rst_datain", DataIn, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        Resetn = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);

        run_tuple(8'd1, 8'd2, 8'd3, 8'd2, 8'd11);
        run_tuple(8'd2, 8'd3, 8'd5, 8'd4, 8'd49);
        run_tuple(8'd3, 8'd0, 8'd0, 8'd10, 8'd44);
        tick();

        // Back-pressure: second tuple parks in WAIT_RES behind an unread result.
        out_ready = 1'b0;
        run_tuple(8'd1, 8'd2, 8'd3, 8'd2, 8'd11);
        accept(8'd0, 8'd0, 8'd7, 8'd1);
        repeat (30) tick();
        check("stall_busy", busy, 1);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_data", out_data, 11);
        check("stall_go", Go, 0);
        check("stall_datain_x", DataIn, 1);
        out_ready = 1'b1;
        check("drain_first", out_data, 11);
        tick();
        check("capture_valid", out_valid, 1);
        check("capture_data", out_data, 7);
        check("capture_idle", busy, 0);
        tick();
        check("second_drained", out_valid, 0);

        // Asynchronous reset during B's Go pulse.
        accept(8'd5, 8'd6, 8'd7, 8'd3);
        repeat (4) tick();
        check("pre_rst_go", Go, 1);
        check("pre_rst_datain_b", DataIn, 6);
        #2;
        Resetn = 1'b0;
        #1;
        check("async_rst_go", Go, 0);
        check("async_rst_datain", DataIn, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_busy", busy, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        run_tuple(8'd2, 8'd2, 8'd2, 8'd2, 8'd14);

`ifdef POLY_FEEDER_TIMEOUT_EN
        rv_kill = 1'b1;
        accept(8'd1, 8'd1, 8'd1, 8'd1);
        repeat (42) tick();
        check("timeout_not_yet", timeout_err, 0);
        tick();
        check("timeout_err", timeout_err, 1);
        check("timeout_in_ready", in_ready, 1);
        check("timeout_busy", busy, 0);
        rv_kill = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
